// File: rtl/mem_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
//   - Default port widths for the requester and memory interfaces.
//   - Response owner encoding and the all-bytes enable constant.
//   - Response-tracking FSM state type. Each state is encoded as {pending, owner},
//     so the two tracking flags can be read directly from the state register.
package mem_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;

  localparam logic       OWN_IF = 1'b0;
  localparam logic       OWN_D  = 1'b1;
  localparam logic [3:0] BE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RESP_IF = 2'b10,
    ST_RESP_D  = 2'b11
  } resp_state_t;

  // A read grant this cycle means a response is owed next cycle to 'owner'.
  // With no read grant (idle cycle or store), nothing is owed.
  function automatic resp_state_t next_resp_state(input logic read_gnt,
                                                  input logic owner);
    if (read_gnt) begin
      return (owner == OWN_D) ? ST_RESP_D : ST_RESP_IF;
    end
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears the count
//   inc  : advance by one, holding once MAX is reached
//   clr  : return to zero (takes priority over inc)
//   cnt  : current count
module sat_counter
  import mem_pkg::*;
#(
  parameter int CNT_W = 2,
  parameter int MAX   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_W'(MAX))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported, synchronous-read memory between instruction
// fetch (IF) and load/store (D). One access per cycle; D has priority, but IF is
// forced through after MAX_WAIT consecutive denials. Read data is routed back to
// its owner exactly one cycle after the grant.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr                 fetch read request and byte address
//   if_gnt/if_rvalid/if_rdata      fetch accept, read-data valid, read data
//   d_req/d_we/d_be/d_addr/d_wdata load/store request, write enable, byte enables,
//                                  byte address, store data
//   d_gnt/d_rvalid/d_rdata         data accept, load-data valid, load data
//   mem_en/mem_we/mem_be           memory strobe, write enable, byte enables
//   mem_addr/mem_wdata/mem_rdata   memory word address, write data, read data
module unified_mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic             grant_if;
  logic             grant_d;
  logic             store_gnt;
  logic             read_gnt;
  logic             owner_d;
  logic             wait_inc;
  logic             wait_clr;
  logic [CNT_W-1:0] wait_cnt;
  resp_state_t      state_q;
  resp_state_t      state_d;
  logic             pending;

  // Byte-offset bits never reach the memory; misaligned addresses are silently
  // truncated to their containing word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  sat_counter #(
    .CNT_W (CNT_W),
    .MAX   (MAX_WAIT)
  ) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wait_inc),
    .clr (wait_clr),
    .cnt (wait_cnt)
  );

  // Arbitration. Everything is held off while rst is asserted so that a request
  // presented during reset is neither accepted nor answered.
  always_comb begin
    grant_if  = ~rst & if_req & (~d_req | (wait_cnt == CNT_W'(MAX_WAIT)));
    grant_d   = ~rst & d_req & ~grant_if;
    store_gnt = grant_d & d_we;
    read_gnt  = grant_if | (grant_d & ~d_we);
    owner_d   = grant_if ? OWN_IF : OWN_D;
    state_d   = next_resp_state(read_gnt, owner_d);
    wait_inc  = if_req & ~grant_if;
    wait_clr  = grant_if | ~if_req;
  end

  // Memory drive. Address/byte-enables are zeroed on idle cycles so the bus is
  // quiet when nothing is granted.
  always_comb begin
    mem_en    = grant_if | grant_d;
    mem_we    = store_gnt;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = rst ? '0 : d_wdata;
    if (store_gnt) begin
      mem_be = d_be;
    end else if (mem_en) begin
      mem_be = BE_ALL;
    end
    if (grant_if) begin
      mem_addr = if_addr[ADDR_W-1:2];
    end else if (grant_d) begin
      mem_addr = d_addr[ADDR_W-1:2];
    end
  end

  assign if_gnt = grant_if;
  assign d_gnt  = grant_d;

  // Response tracking: the state register holds {pending, owner} of the read
  // issued last cycle; back-to-back grants move directly between RESP states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read data is a pass-through of the macro output, shown on both ports only in
  // a response cycle so the ports read zero when no response is owed.
  always_comb begin
    pending   = ~rst & (state_q != ST_IDLE);
    if_rvalid = ~rst & (state_q == ST_RESP_IF);
    d_rvalid  = ~rst & (state_q == ST_RESP_D);
    if_rdata  = pending ? mem_rdata : '0;
    d_rdata   = pending ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int          cyc;
    logic        own;   // 0 = IF, 1 = D
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] ref_mem [0:255];
  logic [31:0] mem_arr [0:255];

  unified_mem_arbiter #(
    .ADDR_W   (10),
    .DATA_W   (32),
    .MAX_WAIT (3),
    .CNT_W    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Memory macro: synchronous read, write-first, preloaded while rst is high.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
      mem_arr[0] <= 32'h401180B3;
      mem_arr[1] <= 32'h00208133;
      mem_arr[2] <= 32'h002081B3;
      mem_arr[3] <= 32'h12345678;
      mem_arr[5] <= 32'hCAFEF00D;
      mem_rdata  <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) begin
        mem_arr[mem_addr] <= be_merge(mem_arr[mem_addr], mem_wdata, mem_be);
        mem_rdata         <= be_merge(mem_arr[mem_addr], mem_wdata, mem_be);
      end else begin
        mem_rdata <= mem_arr[mem_addr];
      end
    end
  end

  task automatic set_idle();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_be    = 4'b0000;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  // Advance one cycle; responses owed to the current cycle are popped from the
  // scoreboard and compared at the falling edge.
  task automatic next_cycle();
    @(negedge clk);
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_assert++;
        if (if_rvalid !== (e.own == 1'b0) || d_rvalid !== (e.own == 1'b1) ||
            (e.own ? d_rdata : if_rdata) !== e.data) begin
          n_fail++;
          $display("FAIL response cyc=%0d: if_rvalid=%b d_rvalid=%b if_rdata=%h d_rdata=%h, required owner=%0d data=%h",
                   cyc, if_rvalid, d_rvalid, if_rdata, d_rdata, e.own, e.data);
        end
      end else begin
        n_assert++;
        if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL spurious_rvalid cyc=%0d: if_rvalid=%b d_rvalid=%b, required 0 0",
                   cyc, if_rvalid, d_rvalid);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic own, input logic [31:0] data);
    exp_t x;
    x.cyc  = cyc + 1;
    x.own  = own;
    x.data = data;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    if_req = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    n_assert++;
    if (if_gnt !== 1'b0 || mem_en !== 1'b0 || if_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_grant: if_gnt=%b mem_en=%b if_rvalid=%b, required 0 0 0",
               if_gnt, mem_en, if_rvalid);
    end
    next_cycle();
    rst = 1'b0;
    set_idle();
    mon_en = 1'b1;
    #1;
    n_assert++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we} !== 6'b0 ||
        mem_be !== 4'b0 || mem_addr !== 8'd0 || if_rdata !== 32'd0 || d_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ctl=%b be=%b addr=%h if_rdata=%h d_rdata=%h, required all 0",
               {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we}, mem_be, mem_addr, if_rdata, d_rdata);
    end
    n_assert++;
    if (dut.wait_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_wait_cnt: got %0d, required 0", dut.wait_cnt);
    end
  endtask

  task automatic test_if_stream();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      set_idle();
      if_req  = 1'b1;
      if_addr = 10'(4 * i);
      #1;
      n_assert++;
      if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== 8'(i) || mem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL if_stream_%0d: if_gnt=%b d_gnt=%b mem_addr=%0d mem_we=%b, required 1 0 %0d 0",
                 i, if_gnt, d_gnt, mem_addr, mem_we, i);
      end
      push_exp(1'b0, ref_mem[i]);
    end
    next_cycle();
    set_idle();
  endtask

  task automatic test_store_load();
    next_cycle();
    set_idle();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b1111; d_addr = 10'h010; d_wdata = 32'hDEADBEEF;
    #1;
    n_assert++;
    if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1111 || mem_addr !== 8'd4 ||
        mem_wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL store_drive: d_gnt=%b mem_we=%b mem_be=%b mem_addr=%0d mem_wdata=%h, required 1 1 1111 4 deadbeef",
               d_gnt, mem_we, mem_be, mem_addr, mem_wdata);
    end
    ref_mem[4] = be_merge(ref_mem[4], 32'hDEADBEEF, 4'b1111);
    next_cycle();
    d_we = 1'b0; d_wdata = '0;
    #1;
    n_assert++;
    if (d_gnt !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b1111) begin
      n_fail++;
      $display("FAIL load_drive: d_gnt=%b mem_we=%b mem_be=%b, required 1 0 1111",
               d_gnt, mem_we, mem_be);
    end
    push_exp(1'b1, ref_mem[4]);
    next_cycle();
    set_idle();
  endtask

  task automatic test_byte_store();
    logic [9:0]  addrs [2];
    logic [31:0] exp_w [2];
    addrs[0] = 10'h020;
    addrs[1] = 10'h014;
    exp_w[0] = 32'h0000AB00;
    exp_w[1] = 32'hCAFEAB0D;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      set_idle();
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_addr = addrs[k]; d_wdata = 32'h0000AB00;
      #1;
      n_assert++;
      if (mem_be !== 4'b0010 || mem_we !== 1'b1) begin
        n_fail++;
        $display("FAIL byte_store_be_%0d: mem_be=%b mem_we=%b, required 0010 1", k, mem_be, mem_we);
      end
      ref_mem[addrs[k][9:2]] = be_merge(ref_mem[addrs[k][9:2]], 32'h0000AB00, 4'b0010);
      next_cycle();
      set_idle();
      next_cycle();
      d_req = 1'b1; d_addr = addrs[k];
      n_assert++;
      if (ref_mem[addrs[k][9:2]] !== exp_w[k]) begin
        n_fail++;
        $display("FAIL byte_merge_model_%0d: got %h, required %h", k, ref_mem[addrs[k][9:2]], exp_w[k]);
      end
      push_exp(1'b1, exp_w[k]);
      next_cycle();
      set_idle();
    end
  endtask

  task automatic test_starvation();
    logic exp_if  [5];
    int   exp_cnt [5];
    exp_if  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_cnt = '{1, 2, 3, 0, 1};
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      if (k > 0) begin
        n_assert++;
        if (dut.wait_cnt !== 2'(exp_cnt[k-1])) begin
          n_fail++;
          $display("FAIL starve_cnt_%0d: wait_cnt=%0d, required %0d", k - 1, dut.wait_cnt, exp_cnt[k-1]);
        end
      end
      if_req = 1'b1; if_addr = 10'h008;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'b0000; d_addr = 10'h004;
      #1;
      n_assert++;
      if (if_gnt !== exp_if[k] || d_gnt !== ~exp_if[k]) begin
        n_fail++;
        $display("FAIL starve_grant_%0d: if_gnt=%b d_gnt=%b, required %b %b",
                 k, if_gnt, d_gnt, exp_if[k], ~exp_if[k]);
      end
      push_exp(~exp_if[k], exp_if[k] ? ref_mem[2] : ref_mem[1]);
    end
    next_cycle();
    n_assert++;
    if (dut.wait_cnt !== 2'(exp_cnt[4])) begin
      n_fail++;
      $display("FAIL starve_cnt_4: wait_cnt=%0d, required %0d", dut.wait_cnt, exp_cnt[4]);
    end
    set_idle();
  endtask

  task automatic test_misaligned();
    next_cycle();
    set_idle();
    if_req = 1'b1; if_addr = 10'h00E;
    #1;
    n_assert++;
    if (if_gnt !== 1'b1 || mem_addr !== 8'd3) begin
      n_fail++;
      $display("FAIL misaligned_addr: if_gnt=%b mem_addr=%0d, required 1 3", if_gnt, mem_addr);
    end
    push_exp(1'b0, ref_mem[3]);
    next_cycle();
    set_idle();
  endtask

  task automatic test_back_to_back();
    // IF read, D load, D store, IF read, D load of the stored word, one per cycle.
    next_cycle();
    set_idle();
    if_req = 1'b1; if_addr = 10'h004;
    push_exp(1'b0, ref_mem[1]);
    next_cycle();
    set_idle();
    d_req = 1'b1; d_addr = 10'h014;
    push_exp(1'b1, ref_mem[5]);
    next_cycle();
    d_we = 1'b1; d_be = 4'b1111; d_addr = 10'h018; d_wdata = 32'h55AA33CC;
    ref_mem[6] = 32'h55AA33CC;
    #1;
    n_assert++;
    if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'd6) begin
      n_fail++;
      $display("FAIL b2b_store: d_gnt=%b mem_we=%b mem_addr=%0d, required 1 1 6", d_gnt, mem_we, mem_addr);
    end
    next_cycle();
    set_idle();
    if_req = 1'b1; if_addr = 10'h00C;
    push_exp(1'b0, ref_mem[3]);
    next_cycle();
    set_idle();
    d_req = 1'b1; d_addr = 10'h018;
    push_exp(1'b1, ref_mem[6]);
    next_cycle();
    set_idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    ref_mem[0] = 32'h401180B3;
    ref_mem[1] = 32'h00208133;
    ref_mem[2] = 32'h002081B3;
    ref_mem[3] = 32'h12345678;
    ref_mem[5] = 32'hCAFEF00D;

    test_reset();
    test_if_stream();
    test_store_load();
    test_byte_store();
    test_starvation();
    test_misaligned();
    test_back_to_back();
    next_cycle();
    next_cycle();

    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, synchronous-read unified instruction/data memory between two requesters: instruction fetch (IF) and load/store (D).
- One access is granted per cycle. D has priority. A starvation counter forces an IF grant after MAX_WAIT consecutive IF denials.
- Routes each read response back to its owner one cycle after the grant.
- Sits between the fetch stage / LSU and the memory macro; it replaces the combinational instruction ROM path.

Parameters:
- ADDR_W, 10, byte-address width of both requester ports.
- DATA_W, 32, data word width.
- MAX_WAIT, 3, consecutive cycles IF may be denied while requesting; IF wins the next arbitration after that.
- CNT_W, 2, width of the starvation counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  store byte enables.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_addr  out  ADDR_W-2  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Clears pending, resp_owner and wait_cnt.
  - All outputs are 0 in the cycle after reset and while rst is held, including rvalid.
  - A read granted in the cycle reset is applied produces no rvalid.
- Arbitration is combinational on the current cycle:
  - grant_if = if_req & (~d_req | wait_cnt == MAX_WAIT).
  - grant_d = d_req & ~grant_if.
  - if_gnt and d_gnt are never both 1.
- Memory drive:
  - mem_en = grant_if | grant_d.
  - mem_addr = the granted requester's addr[ADDR_W-1:2]; the low two address bits are ignored (no misalignment trap).
  - mem_we = grant_d & d_we. mem_be = d_be on a store, 4'b1111 otherwise.
  - mem_wdata = d_wdata.
- Response tracking (registered):
  - pending <= 1 if this cycle has a read grant, i.e. grant_if, or grant_d with d_we=0.
  - resp_owner <= IF or D accordingly.
  - Stores never set pending and never raise d_rvalid.
- Response output, in the cycle after the grant:
  - if_rvalid = pending & owner==IF; d_rvalid = pending & owner==D.
  - rdata = mem_rdata, combinational pass-through, driven to both rdata ports.
  - Read latency is fixed at 1 cycle. Back-to-back grants are allowed every cycle, so throughput is 1 access per cycle.
- Starvation counter wait_cnt:
  - Increments when if_req=1 and grant_if=0.
  - Clears to 0 on grant_if, or when if_req=0.
  - Saturates at MAX_WAIT.
- FSM, states derived from {pending, resp_owner}:
  - IDLE → RESP_IF on grant_if.
  - IDLE → RESP_D on a load grant.
  - Any state → IDLE when there is no read grant.
  - RESP_x → RESP_y directly on a back-to-back grant.
- Boundary cases:
  - Simultaneous if_req and d_req with wait_cnt<MAX_WAIT → D wins.
  - Simultaneous requests with wait_cnt==MAX_WAIT → IF wins, wait_cnt → 0.
  - A requester whose gnt=0 must hold its request and its address, data and byte-enable inputs stable until granted. The arbiter does not latch them.
  - A store followed by a load to the same word on the next cycle returns the new data; memory write-first is assumed by the memory macro contract.

Decomposition:
- Shared package, mem_pkg:
  - Owner encoding: OWN_IF = 1'b0, OWN_D = 1'b1.
  - Default widths ADDR_W and DATA_W.
  - Byte-enable constant BE_ALL = 4'b1111.
- The starvation counter is a natural sub-module, sat_counter (inc, clr, saturate at MAX).
- Arbitration and response tracking stay in the top-level module.

Test Plan:
- IF-only stream, if_addr = 0, 4, 8 on consecutive cycles → if_gnt=1 each cycle; if_rvalid on cycles 1–3 with mem words 0, 1, 2 (e.g. 32'h401180B3 at word 0).
- Store d_addr=0x10, d_wdata=32'hDEADBEEF, d_be=4'b1111, then a load from 0x10 → mem_we=1 and no d_rvalid for the store; d_rvalid one cycle after the load grant with d_rdata=32'hDEADBEEF.
- d_req and if_req held high together for 5 cycles, MAX_WAIT=3 → grants are D, D, D, IF, D; wait_cnt goes 1, 2, 3, 0, 1.
- Byte store d_be=4'b0010, d_wdata=32'h0000AB00 to a word holding 0 → a later load returns 32'h0000AB00.
- rst asserted in the cycle an IF read is granted → no if_rvalid the next cycle; all outputs 0; wait_cnt=0.
- Misaligned fetch if_addr=0x0E → mem_addr=3; if_rvalid returns word 3.
